// File: rtl/dma_request_arbiter_pkg.sv
// Shared types and helpers for the DMA request arbiter.
// Holds the FSM state encoding and the burst-length calculation.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_REQ_DEF = 2;
  localparam int GRANT_W     = grant_w(NUM_REQ_DEF);

  // Burst = min(remaining, max burst, bytes left before the next boundary).
  // Boundary is a power of two, so the mask keeps the low address bits only.
  function automatic logic [31:0] burst_len(input logic [31:0] addr,
                                            input logic [31:0] rem,
                                            input logic [31:0] max_b,
                                            input logic [31:0] boundary);
    logic [31:0] room;
    logic [31:0] len;
    room = boundary - (addr & (boundary - 32'd1));
    len  = rem;
    if (max_b < len) len = max_b;
    if (room < len)  len = room;
    return len;
  endfunction

endpackage

// File: rtl/dma_request_arbiter_if.sv
// Requester-side and DMA-engine-side signals of the arbiter.
// slave = arbiter view, master = requesters/engine view.
interface dma_request_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int GW      = dma_arb_pkg::grant_w(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_read_i;
  logic [NUM_REQ-1:0][31:0] req_addr_i;
  logic [NUM_REQ-1:0][31:0] req_len_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       req_done_o;
  logic                     dma_enable_o;
  logic                     dma_read_o;
  logic [31:0]              dma_addr_o;
  logic [31:0]              dma_len_o;
  logic                     dma_interrupt_i;
  logic                     busy_o;
  logic [GW-1:0]            grant_id_o;

  modport slave (
    input  req_valid_i, req_read_i, req_addr_i, req_len_i, dma_interrupt_i,
    output req_ready_o, req_done_o, dma_enable_o, dma_read_o, dma_addr_o,
           dma_len_o, busy_o, grant_id_o
  );

  modport master (
    output req_valid_i, req_read_i, req_addr_i, req_len_i, dma_interrupt_i,
    input  req_ready_o, req_done_o, dma_enable_o, dma_read_o, dma_addr_o,
           dma_len_o, busy_o, grant_id_o
  );
endinterface

// File: rtl/dma_request_arbiter_rr.sv
// Combinational round-robin pick: first valid requester after ptr_i.
module dma_rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = GRANT_W
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [GW-1:0]      gnt_idx_o,
  output logic               any_o
);

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_o && valid_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        any_o     = 1'b1;
        gnt_idx_o = GW'((int'(ptr_i) + i) % NUM_REQ);
        gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_request_arbiter.sv
// Round-robin sharing of one DMA engine; splits transfers into capped,
// boundary-respecting bursts.
//   state | meaning
//   IDLE  | waiting for a request, grants combinationally
//   CALC  | compute next burst address/length
//   ISSUE | burst running on the engine, wait for interrupt
//   DONE  | one-cycle done pulse to the owner
module dma_request_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_BURST_BYTES = 256,
  parameter int BOUNDARY_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dma_request_arbiter_if.slave  bus
);

  localparam int GW = grant_w(NUM_REQ);

  state_e             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [31:0]        cur_addr_q, cur_addr_d;
  logic [31:0]        rem_len_q, rem_len_d;
  logic [31:0]        dma_addr_q, dma_addr_d;
  logic [31:0]        dma_len_q, dma_len_d;
  logic               dma_read_q, dma_read_d;
  logic [NUM_REQ-1:0] req_ready, req_done;
  logic [NUM_REQ-1:0] gnt;
  logic [GW-1:0]      gnt_idx;
  logic               gnt_any;

  dma_rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .valid_i   (bus.req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    dma_addr_d = dma_addr_q;
    dma_len_d  = dma_len_q;
    dma_read_d = dma_read_q;
    req_ready  = '0;
    req_done   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready  = gnt;
          grant_d    = gnt_idx;
          rr_ptr_d   = gnt_idx;
          cur_addr_d = bus.req_addr_i[gnt_idx];
          rem_len_d  = bus.req_len_i[gnt_idx];
          dma_read_d = bus.req_read_i[gnt_idx];
          state_d    = (bus.req_len_i[gnt_idx] == 32'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        dma_addr_d = cur_addr_q;
        dma_len_d  = burst_len(cur_addr_q, rem_len_q, 32'(MAX_BURST_BYTES),
                               32'(BOUNDARY_BYTES));
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (bus.dma_interrupt_i) begin
          cur_addr_d = cur_addr_q + dma_len_q;
          rem_len_d  = rem_len_q - dma_len_q;
          state_d    = (rem_len_q == dma_len_q) ? DONE : CALC;
        end
      end
      DONE: begin
        req_done[grant_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= GW'(NUM_REQ - 1);
      grant_q    <= '0;
      cur_addr_q <= '0;
      rem_len_q  <= '0;
      dma_addr_q <= '0;
      dma_len_q  <= '0;
      dma_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      dma_addr_q <= dma_addr_d;
      dma_len_q  <= dma_len_d;
      dma_read_q <= dma_read_d;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.req_done_o   = req_done;
  assign bus.dma_enable_o = (state_q == ISSUE);
  assign bus.dma_read_o   = dma_read_q;
  assign bus.dma_addr_o   = dma_addr_q;
  assign bus.dma_len_o    = dma_len_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.grant_id_o   = grant_q;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Self-checking bench: fixed transfer table, corner sequences, and random
// traffic checked against a burst/round-robin reference model.
module tb_dma_request_arbiter;

  localparam int NR   = 2;
  localparam int MAXB = 256;
  localparam int BND  = 4096;

  typedef logic [31:0] arr_t [16];
  typedef struct {
    int          id;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] len;
    int          n;
    logic [31:0] a [4];
    logic [31:0] l [4];
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dma_request_arbiter_if #(.NUM_REQ(NR)) bus ();

  dma_request_arbiter #(
    .NUM_REQ(NR), .MAX_BURST_BYTES(MAXB), .BOUNDARY_BYTES(BND)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total  = 0;
  int   passed = 0;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int id, input bit rd, input logic [31:0] addr,
                         input logic [31:0] len, input int n,
                         input logic [31:0] a0, input logic [31:0] l0,
                         input logic [31:0] a1, input logic [31:0] l1,
                         input logic [31:0] a2, input logic [31:0] l2);
    vecs[i].id = id; vecs[i].rd = rd; vecs[i].addr = addr; vecs[i].len = len; vecs[i].n = n;
    vecs[i].a[0] = a0; vecs[i].l[0] = l0; vecs[i].a[1] = a1; vecs[i].l[1] = l1;
    vecs[i].a[2] = a2; vecs[i].l[2] = l2; vecs[i].a[3] = 0;  vecs[i].l[3] = 0;
  endtask

  // Reference: walk the transfer, each burst takes the smallest of what is
  // left, the burst cap, and the distance to the next boundary.
  function automatic int model_bursts(input logic [31:0] addr, input logic [31:0] len,
                                      output arr_t a, output arr_t l);
    longint cur, rem, room, b;
    int n;
    cur = longint'(addr);
    rem = longint'(len);
    n   = 0;
    a   = '{default: 32'd0};
    l   = '{default: 32'd0};
    while (rem > 0 && n < 16) begin
      room = BND - (cur % BND);
      b    = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      a[n] = cur[31:0];
      l[n] = b[31:0];
      cur  = (cur + b) % 64'h1_0000_0000;
      rem  = rem - b;
      n++;
    end
    return n;
  endfunction

  // Entered in the acceptance cycle; leaves in the IDLE cycle two after the last interrupt.
  task automatic serve(input int g, input bit rd, input int n, input arr_t ea, input arr_t el,
                       input bit drop, input bit stray);
    logic [NR-1:0] oh;
    oh    = '0;
    oh[g] = 1'b1;
    tick();
    if (drop) bus.req_valid_i[g] = 1'b0;
    #1;
    chk("ready_after_accept", 64'(bus.req_ready_o), 64'(0));
    if (n == 0) begin
      chk("zero_done", 64'(bus.req_done_o), 64'(oh));
      chk("zero_busy", 64'(bus.busy_o), 64'(1));
      chk("zero_enable", 64'(bus.dma_enable_o), 64'(0));
      tick();
      chk("zero_done_end", 64'(bus.req_done_o), 64'(0));
      chk("zero_busy_end", 64'(bus.busy_o), 64'(0));
      chk("zero_enable_end", 64'(bus.dma_enable_o), 64'(0));
      return;
    end
    chk("calc_enable", 64'(bus.dma_enable_o), 64'(0));
    chk("calc_busy", 64'(bus.busy_o), 64'(1));
    if (stray) bus.dma_interrupt_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      bus.dma_interrupt_i = 1'b0;
      chk("burst_enable", 64'(bus.dma_enable_o), 64'(1));
      chk("burst_addr", 64'(bus.dma_addr_o), 64'(ea[k]));
      chk("burst_len", 64'(bus.dma_len_o), 64'(el[k]));
      chk("burst_read", 64'(bus.dma_read_o), 64'(rd));
      chk("burst_grant", 64'(bus.grant_id_o), 64'(g));
      chk("burst_no_done", 64'(bus.req_done_o), 64'(0));
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("enable_hold", 64'(bus.dma_enable_o), 64'(1));
      end
      bus.dma_interrupt_i = 1'b1;
      tick();
      bus.dma_interrupt_i = 1'b0;
      chk("enable_drop", 64'(bus.dma_enable_o), 64'(0));
      if (k == n - 1) begin
        chk("done_pulse", 64'(bus.req_done_o), 64'(oh));
        chk("done_addr_hold", 64'(bus.dma_addr_o), 64'(ea[k]));
        chk("done_len_hold", 64'(bus.dma_len_o), 64'(el[k]));
      end else begin
        chk("mid_no_done", 64'(bus.req_done_o), 64'(0));
      end
    end
    tick();
    chk("idle_no_done", 64'(bus.req_done_o), 64'(0));
    chk("idle_busy", 64'(bus.busy_o), 64'(0));
  endtask

  initial begin
    arr_t          ea, el;
    logic [NR-1:0] oh;
    int            last, g, n, c;
    bit            pend   [NR];
    bit            p_rd   [NR];
    logic [31:0]   p_addr [NR];
    logic [31:0]   p_len  [NR];

    set_vec(0, 0, 1'b1, 32'h0000_1000, 32'd600, 3, 32'h1000, 256, 32'h1100, 256, 32'h1200, 88);
    set_vec(1, 1, 1'b0, 32'h0000_0FF0, 32'd64,  2, 32'h0FF0, 16,  32'h1000, 48,  0, 0);
    set_vec(2, 0, 1'b0, 32'h0000_0000, 32'd256, 1, 32'h0000, 256, 0, 0, 0, 0);
    set_vec(3, 1, 1'b1, 32'h0000_1F80, 32'd300, 2, 32'h1F80, 128, 32'h2000, 172, 0, 0);
    set_vec(4, 0, 1'b1, 32'hFFFF_FFF0, 32'd32,  2, 32'hFFFF_FFF0, 16, 32'h0000, 16, 0, 0);
    set_vec(5, 1, 1'b0, 32'h0000_2010, 32'd1,   1, 32'h2010, 1,   0, 0, 0, 0);
    set_vec(6, 0, 1'b1, 32'h0000_3000, 32'd0,   0, 0, 0, 0, 0, 0, 0);

    bus.req_valid_i     = '0;
    bus.req_read_i      = '0;
    bus.req_addr_i      = '0;
    bus.req_len_i       = '0;
    bus.dma_interrupt_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_enable", 64'(bus.dma_enable_o), 64'(0));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_addr", 64'(bus.dma_addr_o), 64'(0));
    chk("rst_len", 64'(bus.dma_len_o), 64'(0));
    chk("rst_read", 64'(bus.dma_read_o), 64'(0));
    chk("rst_grant", 64'(bus.grant_id_o), 64'(0));
    chk("rst_done", 64'(bus.req_done_o), 64'(0));
    chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // Stray interrupt while idle
    bus.dma_interrupt_i = 1'b1;
    tick();
    bus.dma_interrupt_i = 1'b0;
    tick();
    chk("stray_idle_busy", 64'(bus.busy_o), 64'(0));
    chk("stray_idle_enable", 64'(bus.dma_enable_o), 64'(0));
    chk("stray_idle_len", 64'(bus.dma_len_o), 64'(0));

    // Round-robin with both requesters held valid throughout
    bus.req_addr_i[0] = 32'h100;
    bus.req_addr_i[1] = 32'h200;
    bus.req_len_i[0]  = 32'd16;
    bus.req_len_i[1]  = 32'd16;
    bus.req_read_i    = 2'b11;
    bus.req_valid_i   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      #1;
      oh = '0;
      oh[g] = 1'b1;
      chk("rr_ready", 64'(bus.req_ready_o), 64'(oh));
      chk("rr_busy_at_accept", 64'(bus.busy_o), 64'(0));
      ea = '{default: 32'd0};
      el = '{default: 32'd0};
      ea[0] = (g == 0) ? 32'h100 : 32'h200;
      el[0] = 32'd16;
      serve(g, 1'b1, 1, ea, el, 1'b0, 1'b0);
    end
    bus.req_valid_i = '0;
    tick();

    // Table of single-requester transfers
    for (int i = 0; i < 7; i++) begin
      bus.req_valid_i[vecs[i].id] = 1'b1;
      bus.req_read_i[vecs[i].id]  = vecs[i].rd;
      bus.req_addr_i[vecs[i].id]  = vecs[i].addr;
      bus.req_len_i[vecs[i].id]   = vecs[i].len;
      #1;
      oh = '0;
      oh[vecs[i].id] = 1'b1;
      chk("tbl_ready", 64'(bus.req_ready_o), 64'(oh));
      chk("tbl_busy_at_accept", 64'(bus.busy_o), 64'(0));
      ea = '{default: 32'd0};
      el = '{default: 32'd0};
      for (int j = 0; j < 4; j++) begin
        ea[j] = vecs[i].a[j];
        el[j] = vecs[i].l[j];
      end
      serve(vecs[i].id, vecs[i].rd, vecs[i].n, ea, el, 1'b1, i == 1);
    end

    // Reset while a burst is on the engine
    bus.req_valid_i[0] = 1'b1;
    bus.req_read_i[0]  = 1'b1;
    bus.req_addr_i[0]  = 32'h1000;
    bus.req_len_i[0]   = 32'd600;
    #1;
    chk("rstmid_ready", 64'(bus.req_ready_o), 64'(1));
    tick();
    bus.req_valid_i[0] = 1'b0;
    tick();
    chk("rstmid_enable_before", 64'(bus.dma_enable_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_enable", 64'(bus.dma_enable_o), 64'(0));
    chk("rstmid_busy", 64'(bus.busy_o), 64'(0));
    chk("rstmid_addr", 64'(bus.dma_addr_o), 64'(0));
    chk("rstmid_len", 64'(bus.dma_len_o), 64'(0));
    chk("rstmid_read", 64'(bus.dma_read_o), 64'(0));
    chk("rstmid_done", 64'(bus.req_done_o), 64'(0));
    repeat (3) begin
      tick();
      chk("rstmid_no_done", 64'(bus.req_done_o), 64'(0));
    end
    rst_n = 1'b1;
    bus.req_addr_i[0] = 32'h40;
    bus.req_addr_i[1] = 32'h80;
    bus.req_len_i[0]  = 32'd16;
    bus.req_len_i[1]  = 32'd16;
    bus.req_read_i    = 2'b01;
    bus.req_valid_i   = 2'b11;
    #1;
    chk("rstmid_first_grant", 64'(bus.req_ready_o), 64'(1));
    ea = '{default: 32'd0};
    el = '{default: 32'd0};
    ea[0] = 32'h40;
    el[0] = 32'd16;
    serve(0, 1'b1, 1, ea, el, 1'b1, 1'b0);
    #1;
    chk("rstmid_second_grant", 64'(bus.req_ready_o), 64'(2));
    ea[0] = 32'h80;
    serve(1, 1'b0, 1, ea, el, 1'b1, 1'b0);

    // Random traffic against the reference model
    bus.req_valid_i = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    last = NR - 1;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0 || (i == NR - 1 && !pend[0]))) begin
          pend[i]   = 1'b1;
          p_rd[i]   = 1'($urandom_range(0, 1));
          p_addr[i] = $urandom;
          p_len[i]  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1200));
        end
      end
      for (int i = 0; i < NR; i++) begin
        bus.req_valid_i[i] = pend[i];
        bus.req_read_i[i]  = p_rd[i];
        bus.req_addr_i[i]  = p_addr[i];
        bus.req_len_i[i]   = p_len[i];
      end
      #1;
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (last + k) % NR;
        if (g < 0 && pend[c]) g = c;
      end
      last = g;
      oh = '0;
      oh[g] = 1'b1;
      chk("rand_ready", 64'(bus.req_ready_o), 64'(oh));
      n = model_bursts(p_addr[g], p_len[g], ea, el);
      pend[g] = 1'b0;
      serve(g, p_rd[g], n, ea, el, 1'b1, $urandom_range(0, 3) == 0);
    end
    bus.req_valid_i = '0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_request_arbiter.md
Name: dma_request_arbiter

Overview:
Shares the single DMA engine between NUM_REQ transfer requesters, e.g. the tile scheduler's filter/ifmap/ipsum/bias reads and the opsum writeback. It arbitrates round-robin and splits each accepted transfer into bursts. Each burst is capped at MAX_BURST_BYTES and never crosses a BOUNDARY_BYTES address boundary. It sits between the tile-level controllers and the DMA engine, using the same enable/interrupt handshake the DMA engine already exposes.

Parameters:
NUM_REQ, 2, number of requesters (index 0..NUM_REQ-1)
MAX_BURST_BYTES, 256, maximum bytes per issued burst (power of two)
BOUNDARY_BYTES, 4096, address boundary a burst must not cross (power of two, >= MAX_BURST_BYTES)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  [NUM_REQ]  requester n has a pending transfer
req_read_i  input  [NUM_REQ]  1=read DRAM, 0=write DRAM
req_addr_i  input  [NUM_REQ][31:0]  DRAM byte start address
req_len_i  input  [NUM_REQ][31:0]  transfer length in bytes
req_ready_o  output  [NUM_REQ]  one-hot; request accepted this cycle
req_done_o  output  [NUM_REQ]  one-hot single-cycle pulse; accepted transfer fully complete
dma_enable_o  output  1  burst active; held high until dma_interrupt_i
dma_read_o  output  1  direction of current burst
dma_addr_o  output  32  current burst start address
dma_len_o  output  32  current burst length in bytes
dma_interrupt_i  input  1  single-cycle pulse: current burst finished
busy_o  output  1  transfer in progress (state != IDLE)
grant_id_o  output  $clog2(NUM_REQ)  index of requester currently owned

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Internal rem_len and cur_addr are 0.
- Requester rule: hold valid/read/addr/len stable until req_ready_o; valid may drop after acceptance.
- States: IDLE, CALC, ISSUE, DONE.
- IDLE:
  - If any req_valid_i, grant the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready_o[g] is combinational, high that cycle only.
  - Register grant_id_o=g, rr_ptr=g, cur_addr=addr, rem_len=len, dma_read_o=read.
  - Next state is DONE if len==0, else CALC.
  - No valid: stay in IDLE.
- CALC (1 cycle):
  - dma_addr_o = cur_addr.
  - dma_len_o = min(rem_len, MAX_BURST_BYTES, BOUNDARY_BYTES - (cur_addr mod BOUNDARY_BYTES)).
  - Next state ISSUE.
- ISSUE:
  - dma_enable_o = 1.
  - On dma_interrupt_i: cur_addr += dma_len_o (mod 2^32) and rem_len -= dma_len_o.
  - After the interrupt, next state is DONE if the new rem_len==0, else CALC.
  - dma_enable_o drops in the cycle after the interrupt.
- DONE:
  - req_done_o[grant_id_o] = 1 for exactly one cycle; next state IDLE.
- Latency:
  - Acceptance at cycle T gives dma_enable_o high at T+2.
  - Interrupt at U gives the next burst's enable at U+2, or req_done_o at U+1.
  - A new acceptance is possible at U+2.
  - A zero-length request gets ready at T and done at T+1, with no DMA activity.
- Output holding: dma_addr_o, dma_len_o, dma_read_o and grant_id_o are registered and hold their last values in IDLE/DONE.
- Stray interrupt: dma_interrupt_i outside ISSUE is ignored.
- Simultaneous events:
  - The request set is not sampled outside IDLE; valids arriving during a transfer wait.
  - A requester that reasserts valid in the same cycle its done pulses is considered at the next IDLE.
- Reset mid-operation: immediate return to reset values; the in-flight transfer is abandoned and no done pulse is issued.
- Width rules:
  - Burst length fits 32 bits.
  - The boundary term uses cur_addr[log2(BOUNDARY_BYTES)-1:0].

Decomposition:
- Package dma_arb_pkg holds:
  - state enum {IDLE, CALC, ISSUE, DONE} as logic [1:0];
  - localparam GRANT_W = $clog2(NUM_REQ) default helper;
  - a function burst_len(addr, rem, max, boundary).
- Sub-module dma_rr_arbiter: combinational round-robin grant from req_valid_i and rr_ptr; outputs a one-hot grant plus its index.

Test Plan:
- Single burst split: req0 read addr 0x1000 len 600 → bursts (0x1000,256), (0x1100,256), (0x1200,88), each answered by an interrupt; req_done_o[0] pulses once, one cycle after the third interrupt; dma_read_o=1 throughout.
- Boundary crossing: req1 write addr 0x0FF0 len 64 → bursts (0x0FF0,16), (0x1000,48); dma_read_o=0.
- Round-robin order: from reset, req0 and req1 both held valid continuously (len 16) → grant order 0,1,0,1; exactly one req_ready_o bit per acceptance; enable high two cycles after each ready.
- Zero length: req0 len 0 → ready at T, done at T+1; dma_enable_o never asserts; busy_o high only at T+1.
- Reset during ISSUE: rst_n low while dma_enable_o=1 → all outputs 0 asynchronously and no done pulse; after release, with req0 and req1 both valid, req0 is granted.
- Stray interrupt: dma_interrupt_i pulsed in IDLE and in CALC → no state change, no address/length update, burst sequence unaffected.
